kbd_ascii_fifo: RTL

Consumes raw PS/2 Set-2 scan-code bytes from the `ps2_keyboard` receiver FIFO and decodes make/break/extended prefixes. It tracks the Shift, Caps Lock and Ctrl state and converts key presses to ASCII. Results go into a 16-entry character FIFO that the CPU reads through a show-ahead pop interface. The block sits between the PS/2 receiver and the CPU memory-mapped keyboard port, and replaces raw scan-code buffering with ready-to-use characters.

---
 rtl/kbd_ascii_fifo.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/kbd_ascii_fifo.sv
// PS/2 Set-2 scan-code decoder with modifier tracking and ASCII FIFO.
// Pops bytes from the receiver FIFO, pushes characters for the CPU.
module kbd_ascii_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] in_data,
   input  logic       in_ready,
   output logic       in_next_n,
   input  logic       rd_pop,
   output logic [7:0] rd_data,
   output logic       rd_empty,
   output logic       rd_full,
   output logic [4:0] rd_count,
   output logic       ovf,
   input  logic       ovf_clr,
   output logic       mod_shift,
   output logic       mod_caps,
   output logic       mod_ctrl
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [4:0] FULL_CNT = 5'(DEPTH);

   typedef enum logic [1:0] {IDLE, POP, SETTLE, DECODE} state_t;

   state_t        state;
   logic [7:0]    code;
   logic          brk, ext;
   logic          shl, shr, ctrl, caps, caps_held;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [4:0]    count;

   logic [7:0] base, sdig, push_char;
   logic       is_letter, is_digit, push_req;
   logic       do_push, do_pop, full;

   // Unshifted lowercase/digit code for each mapped key, 00h if unmapped
   always_comb begin
      base = 8'h00;
      case (code)
         8'h1C: base = 8'h61; 8'h32: base = 8'h62; 8'h21: base = 8'h63;
         8'h23: base = 8'h64; 8'h24: base = 8'h65; 8'h2B: base = 8'h66;
         8'h34: base = 8'h67; 8'h33: base = 8'h68; 8'h43: base = 8'h69;
         8'h3B: base = 8'h6A; 8'h42: base = 8'h6B; 8'h4B: base = 8'h6C;
         8'h3A: base = 8'h6D; 8'h31: base = 8'h6E; 8'h44: base = 8'h6F;
         8'h4D: base = 8'h70; 8'h15: base = 8'h71; 8'h2D: base = 8'h72;
         8'h1B: base = 8'h73; 8'h2C: base = 8'h74; 8'h3C: base = 8'h75;
         8'h2A: base = 8'h76; 8'h1D: base = 8'h77; 8'h22: base = 8'h78;
         8'h35: base = 8'h79; 8'h1A: base = 8'h7A;
         8'h45: base = 8'h30; 8'h16: base = 8'h31; 8'h1E: base = 8'h32;
         8'h26: base = 8'h33; 8'h25: base = 8'h34; 8'h2E: base = 8'h35;
         8'h36: base = 8'h36; 8'h3D: base = 8'h37; 8'h3E: base = 8'h38;
         8'h46: base = 8'h39;
         8'h29: base = 8'h20; 8'h5A: base = 8'h0D; 8'h66: base = 8'h08;
         default: base = 8'h00;
      endcase
   end

   always_comb begin
      sdig = 8'h00;
      case (base[3:0])
         4'd0: sdig = 8'h29; 4'd1: sdig = 8'h21; 4'd2: sdig = 8'h40;
         4'd3: sdig = 8'h23; 4'd4: sdig = 8'h24; 4'd5: sdig = 8'h25;
         4'd6: sdig = 8'h5E; 4'd7: sdig = 8'h26; 4'd8: sdig = 8'h2A;
         4'd9: sdig = 8'h28;
         default: sdig = 8'h00;
      endcase
   end

   always_comb begin
      is_letter = (base >= 8'h61);
      is_digit  = (base[7:4] == 4'h3);
      push_char = base;
      if (is_letter) begin
         if (ctrl)
            push_char = base & 8'h1F;
         else if (mod_shift ^ caps)
            push_char = base ^ 8'h20;
      end else if (is_digit && mod_shift) begin
         push_char = sdig;
      end
      push_req = (state == DECODE) && !brk && (base != 8'h00)
               && (!ext || code == 8'h5A);
   end

   assign mod_shift = shl | shr;
   assign mod_caps  = caps;
   assign mod_ctrl  = ctrl;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state     <= IDLE;
         code      <= 8'h00;
         in_next_n <= 1'b1;
         brk       <= 1'b0;
         ext       <= 1'b0;
         shl       <= 1'b0;
         shr       <= 1'b0;
         ctrl      <= 1'b0;
         caps      <= 1'b0;
         caps_held <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_ready) begin
               code      <= in_data;
               in_next_n <= 1'b0;
               state     <= POP;
            end
            POP: begin
               in_next_n <= 1'b1;
               state     <= SETTLE;
            end
            SETTLE: state <= DECODE;
            DECODE: begin
               state <= IDLE;
               if (code == 8'hF0) begin
                  brk <= 1'b1;
               end else if (code == 8'hE0) begin
                  ext <= 1'b1;
               end else begin
                  brk <= 1'b0;
                  ext <= 1'b0;
                  if (ext) begin
                     if (code == 8'h14) ctrl <= !brk;
                  end else begin
                     case (code)
                        8'h12: shl  <= !brk;
                        8'h59: shr  <= !brk;
                        8'h14: ctrl <= !brk;
                        // Held Caps only toggles once per physical press
                        8'h58: if (brk) begin
                           caps_held <= 1'b0;
                        end else begin
                           caps_held <= 1'b1;
                           if (!caps_held) caps <= !caps;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign full    = (count == FULL_CNT);
   assign do_pop  = rd_pop && (count != 5'd0);
   assign do_push = push_req && (!full || do_pop);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wp    <= '0;
         rp    <= '0;
         count <= 5'd0;
         ovf   <= 1'b0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
         count <= count + {4'b0, do_push} - {4'b0, do_pop};
         if (push_req && !do_push)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= push_char;
   end

   assign rd_count = count;
   assign rd_empty = (count == 5'd0);
   assign rd_full  = full;
   assign rd_data  = rd_empty ? 8'h00 : mem[rp];

endmodule
